t05_mem_access_unit: RTL and testbench
======================================

Name: t05_mem_access_unit

Overview:
- Load/store stage directly downstream of the team 05 ALU.
- Consumes the ALU read_address, write_address and result (store data), plus opcode/funct3 from decode.
- Runs a handshake with the data bus (read/write strobes, busy) and freezes the core while an access is outstanding.
- Returns byte-lane-aligned, sign/zero-extended load data to writeback.

Parameters:
- TIMEOUT, 255: max cycles to wait on bus_busy before aborting (1..1023).
- FREEZE_ON_STORE, 1: 1 = stores also freeze the core until the bus completes; 0 = stores release freeze after the request cycle (posted write).

Ports:
- clk  input  1  system clock, rising edge
- nRst  input  1  asynchronous active-low reset
- ex_valid  input  1  instruction in execute is valid
- opcode  input  7  instruction opcode
- funct3  input  3  access size/sign
- read_address  input  32  load byte address from ALU
- write_address  input  32  store byte address from ALU
- store_data  input  32  ALU result (rs2 value) for stores
- bus_rdata  input  32  bus read data, valid when bus_busy low in WAIT
- bus_busy  input  1  bus still servicing request
- bus_read  output  1  read strobe
- bus_write  output  1  write strobe
- bus_addr  output  32  word-aligned address {addr[31:2],2'b00}
- bus_wdata  output  32  lane-replicated store data
- bus_sel  output  4  byte-lane enables
- load_data  output  32  extended load result
- load_valid  output  1  one-cycle pulse, load_data valid
- freeze  output  1  stall PC/pipeline
- misaligned  output  1  one-cycle pulse, access rejected
- bus_error  output  1  one-cycle pulse, timeout abort

Behaviour:
- Reset (async, nRst=0):
  - state=IDLE; all strobes, pulses and freeze = 0.
  - bus_addr, bus_wdata, bus_sel, load_data = 0.
  - Reset mid-access drops strobes immediately; the access is abandoned.
- Opcode decode:
  - Load = 7'b0000011, store = 7'b0100011; all other opcodes are ignored.
  - Address source: load uses read_address, store uses write_address.
- Size decode (funct3):
  - Loads: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU.
  - Stores: 000 SB, 001 SH, 010 SW.
  - Any other funct3 is treated as misaligned.
- Alignment: halfword needs addr[0]=0; word needs addr[1:0]=00.
- bus_sel:
  - Byte = 4'b0001<<addr[1:0].
  - Half = 4'b0011<<addr[1:0].
  - Word = 4'b1111.
- bus_wdata:
  - Byte: store_data[7:0] replicated x4.
  - Half: store_data[15:0] replicated x2.
  - Word: store_data as is.
- FSM, states IDLE, REQ, WAIT, DONE:
  - IDLE: when ex_valid & load/store & aligned:
    - freeze=1 combinationally in the same cycle.
    - Latch addr/sel/wdata/size; next=REQ.
  - IDLE, misaligned case: misaligned=1 that cycle, no bus activity, no freeze, stay IDLE.
  - REQ: assert bus_read or bus_write for exactly one cycle with the latched addr/sel/wdata; freeze=1; next=WAIT.
  - WAIT: freeze=1; timeout counter increments each cycle.
    - bus_busy=0: capture bus_rdata (loads); next=DONE.
    - Counter reaches TIMEOUT: bus_error=1, load_data=0; next=DONE.
  - Store with FREEZE_ON_STORE=0: REQ goes directly to DONE; freeze=0 in REQ.
  - DONE: freeze=0; load_valid=1 for loads; ex_valid ignored; next=IDLE.
- Guarantees:
  - Minimum load latency is 3 cycles from detection: freeze high in IDLE-detect, REQ and WAIT; load_valid in DONE.
  - Because DONE ignores ex_valid, the same instruction is never re-issued.
- Load extension: select the byte/half by the latched addr[1:0].
  - LB/LH sign-extend; LBU/LHU zero-extend.
  - load_data holds its value until the next load completes.
- Simultaneous events: bus_busy=0 on the TIMEOUT cycle counts as completion, not error.

Test Plan:
- LW at 0x100, bus_busy low after 2 WAIT cycles, bus_rdata=0xDEADBEEF -> bus_read 1 cycle, bus_addr=0x100, bus_sel=1111, freeze high 4 cycles, load_valid with load_data=0xDEADBEEF.
- LB at 0x203, bus_rdata=0x80FF_FF00 -> bus_addr=0x200, bus_sel=1000, load_data=0xFFFFFF80; LBU same -> 0x00000080.
- SH at 0x302, store_data=0x1234ABCD -> bus_write 1 cycle, bus_sel=1100, bus_wdata=0xABCDABCD, no load_valid.
- LW at 0x101 -> misaligned pulse 1 cycle, no bus_read, freeze stays 0.
- bus_busy held high, TIMEOUT=4 -> bus_error pulse after 4 WAIT cycles, load_data=0, freeze drops in DONE.
- nRst low during WAIT -> bus_read/freeze 0 immediately, FSM in IDLE; next LW completes normally.

Source files
------------

// File: rtl/t05_mem_access_unit.sv
// Load/store stage behind the team 05 ALU: drives a one-request-at-a-time data bus
// handshake, freezes the core while an access is outstanding and returns extended load data.
module t05_mem_access_unit #(
    parameter int TIMEOUT         = 255,
    parameter bit FREEZE_ON_STORE = 1'b1
) (
    input  logic        clk,
    input  logic        nRst,
    input  logic        ex_valid,
    input  logic [6:0]  opcode,
    input  logic [2:0]  funct3,
    input  logic [31:0] read_address,
    input  logic [31:0] write_address,
    input  logic [31:0] store_data,
    input  logic [31:0] bus_rdata,
    input  logic        bus_busy,
    output logic        bus_read,
    output logic        bus_write,
    output logic [31:0] bus_addr,
    output logic [31:0] bus_wdata,
    output logic [3:0]  bus_sel,
    output logic [31:0] load_data,
    output logic        load_valid,
    output logic        freeze,
    output logic        misaligned,
    output logic        bus_error
);

    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_STORE = 7'b0100011;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_REQ  = 2'd1;
    localparam logic [1:0] S_WAIT = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;

    localparam logic [9:0] WAIT_LAST = 10'(TIMEOUT - 1);

    logic [1:0]  state_reg;
    logic [31:0] addr_reg;
    logic [1:0]  addr_lo_reg;
    logic [3:0]  sel_reg;
    logic [31:0] wdata_reg;
    logic [2:0]  funct3_reg;
    logic        is_load_reg;
    logic [9:0]  wait_cnt_reg;
    logic [31:0] load_data_reg;
    logic        bus_error_reg;

    logic        is_load;
    logic        is_store;
    logic [31:0] access_addr;
    logic        size_ok;
    logic        align_ok;
    logic        mem_op;
    logic        accept;
    logic [3:0]  sel_next;
    logic [31:0] wdata_next;
    logic [7:0]  rd_byte [4];
    logic [7:0]  byte_pick;
    logic [15:0] half_pick;
    logic [31:0] load_ext;

    assign is_load     = (opcode == OP_LOAD);
    assign is_store    = (opcode == OP_STORE);
    assign access_addr = is_load ? read_address : write_address;
    assign mem_op      = ex_valid && (is_load || is_store);

    always_comb begin
        size_ok = 1'b0;
        if (is_load) begin
            size_ok = (funct3 == 3'b000) || (funct3 == 3'b001) || (funct3 == 3'b010) ||
                      (funct3 == 3'b100) || (funct3 == 3'b101);
        end else if (is_store) begin
            size_ok = (funct3 == 3'b000) || (funct3 == 3'b001) || (funct3 == 3'b010);
        end
    end

    always_comb begin
        align_ok   = 1'b0;
        sel_next   = 4'b1111;
        wdata_next = store_data;
        case (funct3[1:0])
            2'b00: begin
                align_ok   = 1'b1;
                sel_next   = 4'b0001 << access_addr[1:0];
                wdata_next = {4{store_data[7:0]}};
            end
            2'b01: begin
                align_ok   = ~access_addr[0];
                sel_next   = 4'b0011 << access_addr[1:0];
                wdata_next = {2{store_data[15:0]}};
            end
            2'b10: begin
                align_ok   = (access_addr[1:0] == 2'b00);
                sel_next   = 4'b1111;
                wdata_next = store_data;
            end
            default: begin
                align_ok   = 1'b0;
                sel_next   = 4'b1111;
                wdata_next = store_data;
            end
        endcase
    end

    assign accept = (state_reg == S_IDLE) && mem_op && size_ok && align_ok;

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_lane
            assign rd_byte[gi] = bus_rdata[8*gi +: 8];
        end
    endgenerate

    // Lane selection uses the latched low address bits, not the live ALU address.
    assign byte_pick = rd_byte[addr_lo_reg];
    assign half_pick = addr_lo_reg[1] ? bus_rdata[31:16] : bus_rdata[15:0];

    always_comb begin
        case (funct3_reg)
            3'b000:  load_ext = {{24{byte_pick[7]}}, byte_pick};
            3'b001:  load_ext = {{16{half_pick[15]}}, half_pick};
            3'b100:  load_ext = {24'd0, byte_pick};
            3'b101:  load_ext = {16'd0, half_pick};
            default: load_ext = bus_rdata;
        endcase
    end

    always_ff @(posedge clk or negedge nRst) begin
        if (!nRst) begin
            state_reg     <= S_IDLE;
            addr_reg      <= 32'd0;
            addr_lo_reg   <= 2'd0;
            sel_reg       <= 4'd0;
            wdata_reg     <= 32'd0;
            funct3_reg    <= 3'd0;
            is_load_reg   <= 1'b0;
            wait_cnt_reg  <= 10'd0;
            load_data_reg <= 32'd0;
            bus_error_reg <= 1'b0;
        end else begin
            bus_error_reg <= 1'b0;
            case (state_reg)
                S_IDLE: begin
                    if (accept) begin
                        addr_reg    <= {access_addr[31:2], 2'b00};
                        addr_lo_reg <= access_addr[1:0];
                        sel_reg     <= sel_next;
                        wdata_reg   <= wdata_next;
                        funct3_reg  <= funct3;
                        is_load_reg <= is_load;
                        state_reg   <= S_REQ;
                    end
                end
                S_REQ: begin
                    wait_cnt_reg <= 10'd0;
                    state_reg    <= (!is_load_reg && !FREEZE_ON_STORE) ? S_DONE : S_WAIT;
                end
                S_WAIT: begin
                    // Completion wins over timeout when both land on the same cycle.
                    if (!bus_busy) begin
                        if (is_load_reg) begin
                            load_data_reg <= load_ext;
                        end
                        state_reg <= S_DONE;
                    end else if (wait_cnt_reg == WAIT_LAST) begin
                        bus_error_reg <= 1'b1;
                        if (is_load_reg) begin
                            load_data_reg <= 32'd0;
                        end
                        state_reg <= S_DONE;
                    end else begin
                        wait_cnt_reg <= wait_cnt_reg + 10'd1;
                    end
                end
                default: begin
                    state_reg <= S_IDLE;
                end
            endcase
        end
    end

    assign bus_read   = (state_reg == S_REQ) && is_load_reg;
    assign bus_write  = (state_reg == S_REQ) && !is_load_reg;
    assign bus_addr   = addr_reg;
    assign bus_sel    = sel_reg;
    assign bus_wdata  = wdata_reg;
    assign load_data  = load_data_reg;
    assign load_valid = (state_reg == S_DONE) && is_load_reg;
    assign bus_error  = bus_error_reg;
    assign freeze     = nRst && (accept || (state_reg == S_WAIT) ||
                        ((state_reg == S_REQ) && (is_load_reg || FREEZE_ON_STORE)));
    assign misaligned = nRst && (state_reg == S_IDLE) && mem_op && !(size_ok && align_ok);

endmodule

// File: tb/tb_t05_mem_access_unit.sv
// Directed bench for t05_mem_access_unit: stimulus pushes expected bus/result events,
// a negedge monitor pops and compares them whenever the DUT shows an output event.
module tb_t05_mem_access_unit;

    logic        clk;
    logic        nRst;
    logic        ex_valid;
    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic [31:0] read_address;
    logic [31:0] write_address;
    logic [31:0] store_data;
    logic [31:0] bus_rdata;
    logic        bus_busy;
    logic        bus_read;
    logic        bus_write;
    logic [31:0] bus_addr;
    logic [31:0] bus_wdata;
    logic [3:0]  bus_sel;
    logic [31:0] load_data;
    logic        load_valid;
    logic        freeze;
    logic        misaligned;
    logic        bus_error;

    localparam logic [6:0] LD = 7'b0000011;
    localparam logic [6:0] ST = 7'b0100011;
    localparam logic [6:0] OP = 7'b0110011;

    t05_mem_access_unit #(.TIMEOUT(4), .FREEZE_ON_STORE(1'b1)) dut (
        .clk(clk), .nRst(nRst), .ex_valid(ex_valid), .opcode(opcode), .funct3(funct3),
        .read_address(read_address), .write_address(write_address), .store_data(store_data),
        .bus_rdata(bus_rdata), .bus_busy(bus_busy), .bus_read(bus_read), .bus_write(bus_write),
        .bus_addr(bus_addr), .bus_wdata(bus_wdata), .bus_sel(bus_sel), .load_data(load_data),
        .load_valid(load_valid), .freeze(freeze), .misaligned(misaligned), .bus_error(bus_error)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        rd, wr, lv, mis, err;
        logic [31:0] addr;
        logic [3:0]  sel;
        logic [31:0] wdata;
        logic [31:0] data;
        int          id;
    } ev_t;

    ev_t exp_q[$];
    ev_t mon_e;
    int  tests = 0;
    int  fails = 0;
    int  cur_id = 0;

    task automatic check(input string name, input int id, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s (txn %0d): got 0x%08h, expected 0x%08h", name, id, act, exp);
        end
    endtask

    task automatic push_bus(input logic rd, input logic [31:0] a, input logic [3:0] s, input logic [31:0] wd);
        ev_t e;
        e = '{rd: rd, wr: !rd, lv: 1'b0, mis: 1'b0, err: 1'b0, addr: a, sel: s, wdata: wd, data: 32'd0, id: cur_id};
        exp_q.push_back(e);
    endtask

    task automatic push_done(input logic lv, input logic [31:0] d, input logic err);
        ev_t e;
        e = '{rd: 1'b0, wr: 1'b0, lv: lv, mis: 1'b0, err: err, addr: 32'd0, sel: 4'd0, wdata: 32'd0, data: d, id: cur_id};
        exp_q.push_back(e);
    endtask

    task automatic push_mis();
        ev_t e;
        e = '{rd: 1'b0, wr: 1'b0, lv: 1'b0, mis: 1'b1, err: 1'b0, addr: 32'd0, sel: 4'd0, wdata: 32'd0, data: 32'd0, id: cur_id};
        exp_q.push_back(e);
    endtask

    always @(negedge clk) begin
        if (nRst && (bus_read || bus_write || load_valid || misaligned || bus_error)) begin
            if (exp_q.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL unexpected_event: rd=%0b wr=%0b lv=%0b mis=%0b err=%0b, expected no event",
                         bus_read, bus_write, load_valid, misaligned, bus_error);
            end else begin
                mon_e = exp_q.pop_front();
                check("event_flags", mon_e.id, {27'd0, bus_read, bus_write, load_valid, misaligned, bus_error},
                      {27'd0, mon_e.rd, mon_e.wr, mon_e.lv, mon_e.mis, mon_e.err});
                if (mon_e.rd || mon_e.wr) begin
                    check("bus_addr", mon_e.id, bus_addr, mon_e.addr);
                    check("bus_sel", mon_e.id, {28'd0, bus_sel}, {28'd0, mon_e.sel});
                end
                if (mon_e.wr) check("bus_wdata", mon_e.id, bus_wdata, mon_e.wdata);
                if (mon_e.lv) check("load_data", mon_e.id, load_data, mon_e.data);
            end
        end
    end

    // Runs one instruction for a fixed 12-cycle window; bus_busy stays high for busy_n WAIT cycles.
    task automatic do_access(input logic [6:0] op, input logic [2:0] f3, input logic [31:0] addr,
                             input logic [31:0] sdata, input logic [31:0] rdata, input int busy_n,
                             input int exp_freeze);
        int fcnt;
        int wcnt;
        logic strobe;
        cur_id++;
        opcode = op; funct3 = f3; read_address = addr; write_address = addr;
        store_data = sdata; bus_rdata = rdata; bus_busy = 1'b1; ex_valid = 1'b1;
        fcnt = 0; wcnt = -1;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            if (freeze) fcnt++;
            strobe = bus_read || bus_write;
            @(posedge clk);
            #1;
            ex_valid = 1'b0;
            if (strobe) wcnt = 0;
            else if (wcnt >= 0) wcnt++;
            bus_busy = (wcnt < 0) ? 1'b1 : (wcnt < busy_n);
        end
        check("freeze_cycles", cur_id, fcnt, exp_freeze);
    endtask

    initial begin
        nRst = 1'b0; ex_valid = 1'b0; opcode = 7'd0; funct3 = 3'd0; read_address = 32'd0;
        write_address = 32'd0; store_data = 32'd0; bus_rdata = 32'd0; bus_busy = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("reset_strobes", 0, {28'd0, bus_read, bus_write, freeze, load_valid}, 32'd0);
        check("reset_pulses", 0, {30'd0, misaligned, bus_error}, 32'd0);
        check("reset_bus_addr", 0, bus_addr, 32'd0);
        check("reset_wdata_sel", 0, bus_wdata | {28'd0, bus_sel}, 32'd0);
        check("reset_load_data", 0, load_data, 32'd0);
        nRst = 1'b1;
        @(posedge clk); #1;

        push_bus(1'b1, 32'h100, 4'b1111, 32'd0); push_done(1'b1, 32'hDEADBEEF, 1'b0);
        do_access(LD, 3'b010, 32'h100, 32'd0, 32'hDEADBEEF, 1, 4);

        push_bus(1'b1, 32'h200, 4'b1000, 32'd0); push_done(1'b1, 32'hFFFFFF80, 1'b0);
        do_access(LD, 3'b000, 32'h203, 32'd0, 32'h80FFFF00, 0, 3);
        push_bus(1'b1, 32'h200, 4'b1000, 32'd0); push_done(1'b1, 32'h00000080, 1'b0);
        do_access(LD, 3'b100, 32'h203, 32'd0, 32'h80FFFF00, 0, 3);
        push_bus(1'b1, 32'h200, 4'b1100, 32'd0); push_done(1'b1, 32'hFFFF80FF, 1'b0);
        do_access(LD, 3'b001, 32'h202, 32'd0, 32'h80FFFF00, 0, 3);
        push_bus(1'b1, 32'h200, 4'b0011, 32'd0); push_done(1'b1, 32'h0000FF00, 1'b0);
        do_access(LD, 3'b101, 32'h200, 32'd0, 32'h80FFFF00, 0, 3);

        push_bus(1'b0, 32'h300, 4'b1100, 32'hABCDABCD);
        do_access(ST, 3'b001, 32'h302, 32'h1234ABCD, 32'h11111111, 0, 3);
        check("load_data_hold_after_store", cur_id, load_data, 32'h0000FF00);
        push_bus(1'b0, 32'h100, 4'b0010, 32'hEFEFEFEF);
        do_access(ST, 3'b000, 32'h101, 32'h000000EF, 32'd0, 0, 3);
        push_bus(1'b0, 32'h104, 4'b1111, 32'hCAFEF00D);
        do_access(ST, 3'b010, 32'h104, 32'hCAFEF00D, 32'd0, 2, 5);

        push_mis(); do_access(LD, 3'b010, 32'h101, 32'd0, 32'd0, 0, 0);
        push_mis(); do_access(LD, 3'b001, 32'h201, 32'd0, 32'd0, 0, 0);
        push_mis(); do_access(LD, 3'b011, 32'h200, 32'd0, 32'd0, 0, 0);
        push_mis(); do_access(ST, 3'b100, 32'h200, 32'd0, 32'd0, 0, 0);
        do_access(OP, 3'b010, 32'h200, 32'd0, 32'd0, 0, 0);

        push_bus(1'b1, 32'h400, 4'b1111, 32'd0); push_done(1'b1, 32'h00000000, 1'b1);
        do_access(LD, 3'b010, 32'h400, 32'd0, 32'h55555555, 100, 6);
        push_bus(1'b1, 32'h404, 4'b1111, 32'd0); push_done(1'b1, 32'h13579BDF, 1'b0);
        do_access(LD, 3'b010, 32'h404, 32'd0, 32'h13579BDF, 3, 6);
        push_bus(1'b0, 32'h408, 4'b1111, 32'h0F0F0F0F); push_done(1'b0, 32'd0, 1'b1);
        do_access(ST, 3'b010, 32'h408, 32'h0F0F0F0F, 32'd0, 100, 6);
        check("load_data_hold_after_store_timeout", cur_id, load_data, 32'h13579BDF);

        // Reset while the load sits in WAIT: strobes and freeze must drop at once.
        cur_id++;
        push_bus(1'b1, 32'h500, 4'b1111, 32'd0);
        opcode = LD; funct3 = 3'b010; read_address = 32'h500; bus_busy = 1'b1; ex_valid = 1'b1;
        @(posedge clk); #1; ex_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        nRst = 1'b0;
        #1;
        check("reset_mid_strobe_freeze", cur_id, {30'd0, bus_read, freeze}, 32'd0);
        check("reset_mid_bus_addr", cur_id, bus_addr, 32'd0);
        check("reset_mid_load_data", cur_id, load_data, 32'd0);
        @(posedge clk); #1;
        nRst = 1'b1;
        @(posedge clk); #1;

        push_bus(1'b1, 32'h600, 4'b1111, 32'd0); push_done(1'b1, 32'h0A0B0C0D, 1'b0);
        do_access(LD, 3'b010, 32'h600, 32'd0, 32'h0A0B0C0D, 0, 3);

        check("scoreboard_drained", cur_id, exp_q.size(), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
